int_to_fpu: RTL and testbench

//  Operand encoder feeding the FPU. Converts a signed two's-complement integer into the

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/int_to_fpu.sv | 112 +++++++++++
 tb/tb_int_to_fpu.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: status encoding, float field widths, and the encoder FSM states.
// enc_state_t gets its own name so it cannot clash with the FPU core's state_t.
package fpu_pkg;

  localparam int EXP_W    = 10;
  localparam int MANT_W   = 21;
  localparam int EXP_BIAS = 511;

  typedef enum logic [1:0] {
    OVERFLOW  = 2'd0,
    UNDERFLOW = 2'd1,
    EXACT     = 2'd2,
    INEXACT   = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONVERT   = 3'd1,
    NORMALIZE = 3'd2,
    PACK      = 3'd3,
    HOLD      = 3'd4
  } enc_state_t;

endpackage

// File: rtl/int_to_fpu.sv
// Signed integer to {sign, exp(bias 511), mant(hidden 1)} float encoder; result valid 3+lz edges
// after accept (2 for zero). One input in flight: in_ready only in IDLE, result held until out_ready.
module int_to_fpu #(
  parameter int INT_W    = 32,
  parameter int EXP_BIAS = fpu_pkg::EXP_BIAS
) (
  input  logic               clock_100Khz,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INT_W-1:0]   int_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        data_out,
  output fpu_pkg::status_t   status_out
);

  import fpu_pkg::*;

  localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(EXP_BIAS + INT_W - 1);

  enc_state_t              state;
  logic [INT_W-1:0]        int_reg;
  logic [INT_W-1:0]        mag;
  logic [EXP_W-1:0]        exp_reg;
  logic                    sign;
  logic                    zero;
  logic                    int_zero;
  logic [INT_W-1:0]        drop_bits;
  logic [MANT_W-1:0]       mant;

  assign in_ready  = (state == IDLE);
  assign int_zero  = (int_reg == '0);
  assign mant      = mag[INT_W-2 -: MANT_W];
  // Bits below the mantissa field slide to the top; any survivor means truncation lost precision.
  assign drop_bits = mag << (MANT_W + 1);

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= CONVERT;
        end
        CONVERT: begin
          state <= int_zero ? PACK : NORMALIZE;
        end
        NORMALIZE: begin
          if (mag[INT_W-1]) state <= PACK;
        end
        PACK: begin
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      int_reg    <= '0;
      mag        <= '0;
      exp_reg    <= '0;
      sign       <= 1'b0;
      zero       <= 1'b0;
      data_out   <= 32'h0;
      status_out <= EXACT;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) int_reg <= int_in;
        end
        CONVERT: begin
          sign    <= int_reg[INT_W-1];
          // Two's-complement negate; the most negative input maps to 2^(INT_W-1) unsigned.
          mag     <= int_reg[INT_W-1] ? ((~int_reg) + 1'b1) : int_reg;
          exp_reg <= EXP_TOP;
          zero    <= int_zero;
        end
        NORMALIZE: begin
          if (!mag[INT_W-1]) begin
            mag     <= mag << 1;
            exp_reg <= exp_reg - 1'b1;
          end
        end
        PACK: begin
          if (zero) begin
            data_out   <= 32'h0;
            status_out <= EXACT;
          end else begin
            data_out   <= {sign, exp_reg, mant};
            status_out <= (drop_bits != '0) ? INEXACT : EXACT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fpu.sv
`timescale 1ns/1ps
module tb_int_to_fpu;
  import fpu_pkg::*;

  typedef struct {
    logic [31:0] din;
    logic [31:0] data;
    status_t     st;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    status_t     st;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] int_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  status_t     status_out;

  int tests;
  int failed;
  exp_t sb[$];

  int_to_fpu #(.INT_W(32), .EXP_BIAS(511)) dut (
    .clock_100Khz(clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .int_in      (int_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .data_out    (data_out),
    .status_out  (status_out)
  );

  initial clk = 1'b0;
  always #5000 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Drive one accepted input and push its expected result.
  task automatic send(input logic [31:0] v, input logic [31:0] ed, input status_t es, input int el);
    exp_t e;
    @(negedge clk);
    chk("in_ready_before_send", {31'b0, in_ready}, 32'd1);
    int_in   = v;
    in_valid = 1'b1;
    e.data = ed; e.st = es; e.lat = el;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then pop and compare against the scoreboard.
  task automatic wait_result(input string nm);
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      chk({nm, "_timeout"}, {31'b0, out_valid}, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk({nm, "_unexpected_result"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({nm, "_data"}, data_out, e.data);
    chk({nm, "_status"}, {30'b0, status_out}, {30'b0, e.st});
    chk({nm, "_latency"}, lat, e.lat);
  endtask

  task automatic ack(input string nm);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    chk({nm, "_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  vec_t vecs[9];

  initial begin
    tests = 0; failed = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; int_in = 32'h0;

    vecs[0] = '{32'h00000001, 32'h3FE00000, EXACT,   34};
    vecs[1] = '{32'hFFFFFFFA, 32'hC0300000, EXACT,   32};
    vecs[2] = '{32'h7FFFFFFF, 32'h43BFFFFF, INEXACT,  4};
    vecs[3] = '{32'h80000000, 32'hC3C00000, EXACT,    3};
    vecs[4] = '{32'h00000000, 32'h00000000, EXACT,    2};
    vecs[5] = '{32'h00000005, 32'h40280000, EXACT,   32};
    vecs[6] = '{32'h00400001, 32'h42A00000, INEXACT, 12};
    vecs[7] = '{32'h00200001, 32'h42800001, EXACT,   13};
    vecs[8] = '{32'hFFFFFFFF, 32'hBFE00000, EXACT,   34};

    #12000;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_data", data_out, 32'h0);
    chk("reset_status", {30'b0, status_out}, {30'b0, EXACT});
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].din, vecs[i].data, vecs[i].st, vecs[i].lat);
      wait_result($sformatf("vec%0d", i));
      ack($sformatf("vec%0d", i));
    end

    // Backpressure: hold the result, and offer a second input that must be ignored.
    send(32'hFFFFFFFA, 32'hC0300000, EXACT, 32);
    wait_result("hold");
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = (c == 3);
      int_in   = 32'h00000007;
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_data", data_out, 32'hC0300000);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    ack("hold");
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
    end
    chk("ignored_input_no_result", {31'b0, out_valid}, 32'd0);
    chk("ignored_input_data_kept", data_out, 32'hC0300000);

    // Reset in the middle of normalisation drops the conversion.
    @(negedge clk);
    int_in = 32'h00000001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_data", data_out, 32'h0);
    chk("midreset_status", {30'b0, status_out}, {30'b0, EXACT});
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
    end
    chk("midreset_dropped", {31'b0, out_valid}, 32'd0);
    send(32'hFFFFFFFA, 32'hC0300000, EXACT, 32);
    wait_result("after_reset");
    ack("after_reset");
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
